// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and byte-enable decode for dmem_wait
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a :
           size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-byte synchronous write and combinational read
module dmem_array #(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wd,
  output logic [31:0]              rd
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  assign rd = mem[idx];
endmodule

// File: rtl/dmem_wait.sv
// dmem_wait: handshaked data memory with wait states, load extension and error reporting
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 32,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          rvalid,
  output logic [31:0]   rdata,
  output logic          err
);
  localparam int IW = $clog2(DEPTH);
  state_t state, state_d;
  logic [3:0] cnt;
  logic q_we, q_uns, c_we, c_uns, in_wait, accept, bad, commit;
  logic [1:0] q_size, c_size, off;
  logic [IW+1:0] q_addr, c_addr;
  logic [31:0] q_wdata, c_wdata, rd, sh, ld, wd;
  assign ready   = state == IDLE || state == RESP;
  assign rvalid  = state == RESP;
  assign in_wait = state == WAIT;
  assign accept  = req && ready;
  assign bad = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) ||
               size == 2'b11 || addr[AW-1:2] >= (AW-2)'(DEPTH);
  // With LAT=0 the access commits on its accept edge, so the live inputs drive the array
  always_comb begin
    c_we    = in_wait ? q_we : we;
    c_uns   = in_wait ? q_uns : uns;
    c_size  = in_wait ? q_size : size;
    c_addr  = in_wait ? q_addr : addr[IW+1:0];
    c_wdata = in_wait ? q_wdata : wdata;
    commit  = in_wait ? cnt == 4'd1 : accept && !bad && LAT == 0;
    off     = c_size == SZ_BYTE ? c_addr[1:0] : c_size == SZ_HALF ? {c_addr[1], 1'b0} : 2'b00;
    sh      = rd >> {off, 3'b000};
    ld      = c_size == SZ_BYTE ? {{24{~c_uns & sh[7]}}, sh[7:0]} :
              c_size == SZ_HALF ? {{16{~c_uns & sh[15]}}, sh[15:0]} : sh;
    wd      = c_size == SZ_BYTE ? {4{c_wdata[7:0]}} :
              c_size == SZ_HALF ? {2{c_wdata[15:0]}} : c_wdata;
    state_d = state == INIT ? IDLE :
              in_wait ? (cnt == 4'd1 ? RESP : WAIT) :
              accept ? (bad || LAT == 0 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= in_wait ? cnt - 4'd1 : accept ? 4'(LAT) : cnt;
      if (commit) begin
        rdata <= c_we ? '0 : ld;
        err   <= 1'b0;
      end else if (accept && bad) begin
        rdata <= '0;
        err   <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (accept) begin
      q_we    <= we;
      q_uns   <= uns;
      q_size  <= size;
      q_addr  <= addr[IW+1:0];
      q_wdata <= wdata;
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we (commit && c_we),
    .be (byte_en(c_size, c_addr[1:0])),
    .idx(c_addr[IW+1:2]),
    .wd (wd),
    .rd (rd)
  );
endmodule

// File: tb/tb_dmem_wait.sv
// tb_dmem_wait: scoreboard bench for dmem_wait at LAT=2 and LAT=0
module tb_dmem_wait;
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;
  logic clk = 0, rst_n = 1, req2 = 0, req0 = 0, we = 0, uns = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ready2, rvalid2, err2, ready0, rvalid0, err0;
  logic [31:0] rdata2, rdata0;
  int cyc = 0, checks = 0, fails = 0;
  exp_t q2[$], q0[$];
  exp_t e2, e0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_wait #(.DEPTH(128), .AW(32), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .err(err2));
  dmem_wait #(.DEPTH(128), .AW(32), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0));
  always @(negedge clk) if (rvalid2) begin
    checks++;
    if (q2.size() == 0) begin
      fails++;
      $display("FAIL rsp_lat2 unexpected rvalid rdata=%h err=%b cyc=%0d", rdata2, err2, cyc);
    end else begin
      e2 = q2.pop_front();
      if (rdata2 !== e2.d || err2 !== e2.e || cyc != e2.due) begin
        fails++;
        $display("FAIL rsp_lat2 got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                 rdata2, err2, cyc, e2.d, e2.e, e2.due);
      end
    end
  end
  always @(negedge clk) if (rvalid0) begin
    checks++;
    if (q0.size() == 0) begin
      fails++;
      $display("FAIL rsp_lat0 unexpected rvalid rdata=%h err=%b cyc=%0d", rdata0, err0, cyc);
    end else begin
      e0 = q0.pop_front();
      if (rdata0 !== e0.d || err0 !== e0.e || cyc != e0.due) begin
        fails++;
        $display("FAIL rsp_lat0 got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                 rdata0, err0, cyc, e0.d, e0.e, e0.due);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  // d selects the instance: 2 -> LAT=2, 0 -> LAT=0
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
    int n = 0;
    exp_t x;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    if (d == 2) req2 = 1; else req0 = 1;
    while (!(d == 2 ? ready2 : ready0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout dut=%0d addr=%h", d, a);
    end else begin
      x.d = exp_d;
      x.e = exp_e;
      x.due = cyc + 1 + (exp_e ? 0 : d);
      if (d == 2) q2.push_back(x); else q0.push_back(x);
    end
    @(posedge clk);
    #1 req2 = 0; req0 = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q2.size() != 0 || q0.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q2.size() != 0 || q0.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q2.size() + q0.size());
      q2.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #3 rst_n = 0;
    #1;
    chk("rst_ready", {31'b0, ready2}, 0);
    chk("rst_rvalid", {31'b0, rvalid2}, 0);
    chk("rst_err", {31'b0, err2}, 0);
    chk("rst_rdata", rdata2, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 chk("init_ready", {31'b0, ready2}, 0);
    @(posedge clk);
    #1 chk("idle_ready", {31'b0, ready2}, 1);
    issue(2, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
    issue(2, 0, 2'b10, 0, 32'h10, 32'h0, 32'h11223344, 0);
    issue(2, 1, 2'b00, 0, 32'h11, 32'h000000AB, 32'h0, 0);
    issue(2, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1122AB44, 0);
    issue(2, 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFAB, 0);
    issue(2, 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000AB, 0);
    issue(2, 1, 2'b01, 0, 32'h12, 32'h00008001, 32'h0, 0);
    issue(2, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 0);
    issue(2, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8001AB44, 0);
    issue(2, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000AB44, 0);
    issue(2, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    issue(2, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    issue(2, 1, 2'b01, 0, 32'h13, 32'hFFFFFFFF, 32'h0, 1);
    issue(2, 1, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 32'h0, 1);
    issue(2, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    issue(2, 1, 2'b10, 0, 32'h200, 32'hFFFFFFFF, 32'h0, 1);
    issue(2, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    issue(2, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8001AB44, 0);
    issue(2, 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
    drain();
    issue(0, 1, 2'b10, 0, 32'h20, 32'h12345678, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h12345678, 0);
    issue(0, 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000012, 0);
    issue(0, 1, 2'b01, 0, 32'h21, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b01, 0, 32'h22, 32'h0, 32'h00001234, 0);
    drain();
    issue(2, 1, 2'b10, 0, 32'h30, 32'h55AA55AA, 32'h0, 0);
    drain();
    issue(2, 1, 2'b10, 0, 32'h30, 32'hDEADBEEF, 32'h0, 0);
    @(negedge clk);
    rst_n = 0;
    q2.delete();
    #1;
    chk("wait_rst_ready", {31'b0, ready2}, 0);
    chk("wait_rst_rvalid", {31'b0, rvalid2}, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 chk("rel_ready_init", {31'b0, ready2}, 0);
    @(posedge clk);
    #1 chk("rel_ready_idle", {31'b0, ready2}, 1);
    issue(2, 0, 2'b10, 0, 32'h30, 32'h0, 32'h55AA55AA, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
